// File: rtl/output_transfer_controller.sv
`default_nettype none
// output_transfer_controller: buffers per-pixel PE result beats and serialises them into
// channel-major output BRAM writes. Optional macro OUTPUT_RELU_EN clamps negative results to zero.
module output_transfer_controller #(
    parameter int DATA_WIDTH                = 32,
    parameter int OUTPUT_BRAM_DEPTH         = 4096,
    parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
    parameter int OUTPUT_CHANNEL_WIDTH      = 8,
    parameter int OUTPUT_ROW_WIDTH          = 6,
    parameter int OUTPUT_COL_WIDTH          = 6,
    parameter int PARALLEL_CHANNELS         = 4,
    parameter int FIFO_DEPTH                = 8,
    parameter int POINTER_WIDTH             = $clog2(FIFO_DEPTH)
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_enable,
    input  logic                                 i_start_store_process,
    input  logic [OUTPUT_ROW_WIDTH-1:0]          i_output_row,
    input  logic [OUTPUT_COL_WIDTH-1:0]          i_output_col,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_output_feature_start_index_channel,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_output_feature_end_index_channel,
    input  logic                                 i_result_valid,
    input  logic [DATA_WIDTH-1:0]                i_result_data [0:PARALLEL_CHANNELS-1],
    output logic                                 o_result_ready,
    output logic                                 o_bram_wenable,
    output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_bram_waddress,
    output logic [DATA_WIDTH-1:0]                o_bram_wdata,
    output logic                                 o_fifo_full,
    output logic                                 o_fifo_empty,
    output logic [POINTER_WIDTH:0]               o_element_count,
    output logic                                 o_busy,
    output logic                                 o_store_done
);

    localparam int PLANE_WIDTH = OUTPUT_ROW_WIDTH + OUTPUT_COL_WIDTH;
    localparam int K_WIDTH     = (PARALLEL_CHANNELS > 1) ? $clog2(PARALLEL_CHANNELS) : 1;
    localparam int CH_EXT      = OUTPUT_CHANNEL_WIDTH + 2;
    localparam int CNT_W       = POINTER_WIDTH + 1;
    localparam int AW          = OUTPUT_BRAM_ADDRESS_WIDTH;
    localparam int CW          = OUTPUT_CHANNEL_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                  state;
    logic [PLANE_WIDTH-1:0]  plane;
    logic [PLANE_WIDTH-1:0]  pixel;
    logic [CW-1:0]           groups;
    logic [CW-1:0]           group;
    logic [CW-1:0]           end_ch;
    logic [CH_EXT-1:0]       group_ch;
    logic [AW-1:0]           group_base;
    logic [AW-1:0]           group_stride;
    logic [K_WIDTH-1:0]      k;
    logic                    active;
    logic [DATA_WIDTH-1:0]   hold [0:PARALLEL_CHANNELS-1];
    logic [DATA_WIDTH-1:0]   mem  [0:FIFO_DEPTH-1][0:PARALLEL_CHANNELS-1];
    logic [POINTER_WIDTH-1:0] wr_ptr;
    logic [POINTER_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    wen_reg;
    logic [AW-1:0]           waddr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    done_reg;

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    last_k;
    logic                    slot_valid;
    logic [K_WIDTH-1:0]      slot_k;
    logic [CH_EXT-1:0]       slot_ch;
    logic [AW-1:0]           slot_addr;
    logic [DATA_WIDTH-1:0]   slot_data;
    logic [DATA_WIDTH-1:0]   slot_wdata;
    logic [PLANE_WIDTH-1:0]  load_plane;
    logic [CW-1:0]           channel_span;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = i_enable && (state == DRAIN) && i_result_valid && !full;
    assign pop   = i_enable && (state == DRAIN) && !active && !empty;
    assign issue = i_enable && (state == DRAIN) && (active || !empty);

    assign load_plane   = PLANE_WIDTH'(i_output_row) * PLANE_WIDTH'(i_output_col);
    assign channel_span = i_output_feature_end_index_channel - i_output_feature_start_index_channel;

    // The first slot of a beat is taken straight from the FIFO head so the write lands
    // one cycle after the pop; later slots walk the held copy, one plane apart.
    always_comb begin
        slot_k     = active ? k : '0;
        slot_ch    = group_ch + CH_EXT'(slot_k);
        slot_valid = (slot_ch <= CH_EXT'(end_ch));
        slot_addr  = active ? (waddr_reg + AW'(plane)) : (group_base + AW'(pixel));
        slot_data  = active ? hold[k] : mem[rd_ptr][0];
        last_k     = (slot_k == K_WIDTH'(PARALLEL_CHANNELS - 1));
`ifdef OUTPUT_RELU_EN
        slot_wdata = slot_data[DATA_WIDTH-1] ? '0 : slot_data;
`else
        slot_wdata = slot_data;
`endif
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_result_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            plane        <= '0;
            pixel        <= '0;
            groups       <= '0;
            group        <= '0;
            end_ch       <= '0;
            group_ch     <= '0;
            group_base   <= '0;
            group_stride <= '0;
            k            <= '0;
            active       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wen_reg      <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            done_reg     <= 1'b0;
            for (int i = 0; i < PARALLEL_CHANNELS; i++) begin
                hold[i] <= '0;
            end
        end else if (i_enable) begin
            wen_reg  <= 1'b0;
            done_reg <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + POINTER_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + POINTER_WIDTH'(1);
                hold   <= mem[rd_ptr];
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (i_start_store_process) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    plane        <= load_plane;
                    groups       <= CW'(channel_span / PARALLEL_CHANNELS) + CW'(1);
                    end_ch       <= i_output_feature_end_index_channel;
                    group_ch     <= CH_EXT'(i_output_feature_start_index_channel);
                    group_stride <= AW'(load_plane) * AW'(PARALLEL_CHANNELS);
                    group_base   <= '0;
                    group        <= '0;
                    pixel        <= '0;
                    k            <= '0;
                    active       <= 1'b0;
                    wr_ptr       <= '0;
                    rd_ptr       <= '0;
                    count        <= '0;
                    state        <= DRAIN;
                end
                DRAIN: begin
                    if (issue) begin
                        wen_reg   <= slot_valid;
                        waddr_reg <= slot_addr;
                        wdata_reg <= slot_wdata;
                        if (last_k) begin
                            active <= 1'b0;
                            k      <= '0;
                            if (pixel == plane - PLANE_WIDTH'(1)) begin
                                pixel      <= '0;
                                group      <= group + CW'(1);
                                group_ch   <= group_ch + CH_EXT'(PARALLEL_CHANNELS);
                                group_base <= group_base + group_stride;
                                if (group == groups - CW'(1)) begin
                                    state <= DONE;
                                end
                            end else begin
                                pixel <= pixel + PLANE_WIDTH'(1);
                            end
                        end else begin
                            active <= 1'b1;
                            k      <= slot_k + K_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_result_ready  = i_enable && (state == DRAIN) && !full;
    assign o_bram_wenable  = wen_reg && i_enable;
    assign o_bram_waddress = waddr_reg;
    assign o_bram_wdata    = wdata_reg;
    assign o_fifo_full     = full;
    assign o_fifo_empty    = empty;
    assign o_element_count = count;
    assign o_busy          = (state != IDLE);
    assign o_store_done    = done_reg;

endmodule
`default_nettype wire

// File: tb/tb_output_transfer_controller.sv
`default_nettype none
// Randomised bench for output_transfer_controller; expected writes come from a
// channel-major write-list model built per batch.
module tb_output_transfer_controller;
    localparam int DW = 32;
    localparam int PC = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [5:0]    row = '0;
    logic [5:0]    col = '0;
    logic [7:0]    ch_s = '0;
    logic [7:0]    ch_e = '0;
    logic [DW-1:0] rdata [0:PC-1];
    logic          ready;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] words[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    output_transfer_controller dut (
        .i_clock                              (clk),
        .i_reset                              (rst_n),
        .i_enable                             (enable),
        .i_start_store_process                (start),
        .i_output_row                         (row),
        .i_output_col                         (col),
        .i_output_feature_start_index_channel (ch_s),
        .i_output_feature_end_index_channel   (ch_e),
        .i_result_valid                       (valid),
        .i_result_data                        (rdata),
        .o_result_ready                       (ready),
        .o_bram_wenable                       (wen),
        .o_bram_waddress                      (waddr),
        .o_bram_wdata                         (wdata),
        .o_fifo_full                          (full),
        .o_fifo_empty                         (empty),
        .o_element_count                      (count),
        .o_busy                               (busy),
        .o_store_done                         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] store_value(input logic [DW-1:0] x);
`ifdef OUTPUT_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // mode: 0 random payload, 1 value 16*beat+k, 2 first beat carries a negative and a small positive
    task automatic run_batch(input int r, input int c, input int s, input int e,
                             input int vpct, input int epct, input int mode,
                             input int freeze_at, input int reset_at,
                             input bit timed, input bit expect_full);
        int plane, groups, nb, bi, it, budget, post;
        int done_cnt, done_cyc, first_acc, first_wr, peak;
        bit acc;
        plane  = r * c;
        groups = (e - s) / PC + 1;
        nb     = plane * groups;
        words.delete();
        exp_addr.delete();
        exp_data.delete();
        for (int b = 0; b < nb; b++) begin
            for (int kk = 0; kk < PC; kk++) begin
                if (mode == 1)                  words.push_back(DW'(16 * b + kk));
                else if (mode == 2 && b == 0)   words.push_back(kk == 0 ? 32'hFFFF_FFFE : 32'h0000_0005);
                else                            words.push_back($urandom);
            end
        end
        for (int g = 0; g < groups; g++) begin
            for (int p = 0; p < plane; p++) begin
                for (int kk = 0; kk < PC; kk++) begin
                    if (s + g * PC + kk <= e) begin
                        exp_addr.push_back(AW'((g * PC + kk) * plane + p));
                        exp_data.push_back(store_value(words[(g * plane + p) * PC + kk]));
                    end
                end
            end
        end

        row = 6'(r); col = 6'(c); ch_s = 8'(s); ch_e = 8'(e);
        bi = 0; it = 0; acc = 0; post = 0; peak = 0;
        done_cnt = 0; done_cyc = -1; first_acc = -1; first_wr = -1;
        budget = nb * PC * 4 + 100;
        while (1) begin
            @(posedge clk); #1;
            if (acc) bi++;
            start = (it == 0);
            if (it < 3)                                                   enable = 1'b1;
            else if (freeze_at >= 0 && it >= freeze_at && it < freeze_at + 3) enable = 1'b0;
            else                                                          enable = ($urandom_range(99) < epct);
            valid = (bi < nb) && ($urandom_range(99) < vpct);
            for (int kk = 0; kk < PC; kk++) rdata[kk] = (bi < nb) ? words[bi * PC + kk] : '0;

            @(negedge clk);
            cyc++;
            acc = valid && ready;
            if (acc && first_acc < 0) first_acc = cyc;
            if (!enable) check("en_gate", {wen, ready}, 2'b00);
            if (wen) begin
                if (first_wr < 0) first_wr = cyc;
                if (exp_addr.size() == 0) begin
                    check("extra_wr", 64'(exp_addr.size()), 1);
                end else begin
                    check("wr_addr", waddr, exp_addr.pop_front());
                    check("wr_data", wdata, exp_data.pop_front());
                end
            end
            if (int'(count) > peak) peak = int'(count);
            if (full) check("full_gate", {ready, count}, {1'b0, 4'd8});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("idle_at_done", busy, 1'b0);
            end
            if (it == 1) check("busy_load", {busy, ready}, 2'b10);
            if (it == 2) check("ready_drain", {busy, ready}, 2'b11);
            if (it == reset_at) begin
                #2 rst_n = 1'b0;
                #1 check("reset_async", {wen, ready, busy, done, full, empty, count},
                                        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
                check("reset_wbus", {waddr, wdata}, '0);
                @(posedge clk); #1;
                rst_n = 1'b1; start = 1'b0; valid = 1'b0; enable = 1'b1;
                exp_addr.delete();
                exp_data.delete();
                return;
            end
            it++;
            if (done_cnt > 0) post++;
            if (post >= 3) break;
            if (it > budget) begin
                check("timeout_done", 64'(done_cnt), 1);
                break;
            end
        end
        valid = 1'b0; start = 1'b0; enable = 1'b1;
        check("missing_wr", 64'(exp_addr.size()), 0);
        check("done_pulses", 64'(done_cnt), 1);
        check("empty_end", {empty, count}, {1'b1, 4'd0});
        if (timed) begin
            check("first_wr_lat", 64'(first_wr - first_acc), 2);
            check("done_cycle", 64'(done_cyc), 64'(first_wr + PC * nb));
        end
        if (expect_full) check("peak_count", 64'(peak), 8);
    endtask

    initial begin
        for (int kk = 0; kk < PC; kk++) rdata[kk] = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {wen, ready, busy, done, full, empty, count},
                             {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
        rst_n = 1'b1;
        enable = 1'b1;

        run_batch(2, 2, 0, 3, 100, 100, 1, -1, -1, 1, 0);
        run_batch(1, 1, 0, 5, 100, 100, 2, -1, -1, 1, 0);
        run_batch(3, 4, 0, 7, 100, 100, 0, -1, -1, 1, 1);
        run_batch(2, 3, 2, 9, 100, 100, 0, 15, -1, 0, 0);
        run_batch(2, 3, 0, 7, 100, 100, 0, -1, 20, 0, 0);
        run_batch(2, 2, 4, 7, 100, 100, 0, -1, -1, 1, 0);
        run_batch(1, 2, 253, 255, 100, 100, 0, -1, -1, 1, 0);
        run_batch(40, 40, 0, 7, 100, 100, 0, -1, -1, 1, 1);
        for (int n = 0; n < 6; n++) begin
            int r, c, s, e;
            r = $urandom_range(4, 1);
            c = $urandom_range(4, 1);
            s = $urandom_range(200, 0);
            e = s + $urandom_range(11, 0);
            run_batch(r, c, s, e, 70, 85, 0, -1, -1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
